// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: request sampled in cycle t, broadcast and read pulse in t+1; a granted FU is masked until its valid drops.
// Optional contention counter enabled by CDB_ARB_STATS_EN; otherwise conflict_count_out is tied to zero.
module cdb_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int ROB_IX_WIDTH = 3,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [NUM_REQ-1:0]              req_valid_in,
   input  logic [NUM_REQ*ROB_IX_WIDTH-1:0] req_rob_ix_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_value_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dest_in,
   output logic [NUM_REQ-1:0]              read_out,
   output logic                            cdb_valid_out,
   output logic [ROB_IX_WIDTH-1:0]         cdb_rob_ix_out,
   output logic [DATA_WIDTH-1:0]           cdb_value_out,
   output logic [DATA_WIDTH-1:0]           cdb_dest_out,
   output logic [CNT_WIDTH-1:0]            conflict_count_out
);

   localparam int               PTR_W   = $clog2(NUM_REQ);
   localparam logic [PTR_W:0]   NREQ_W  = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(NUM_REQ-1);

   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        grant_ix;
   logic [PTR_W-1:0]        grant_nxt_ptr;
   logic [PTR_W:0]          scan;
   logic                    grant_any;
   logic [NUM_REQ-1:0]      elig;
   logic [NUM_REQ-1:0]      grant_oh;
   logic [ROB_IX_WIDTH-1:0] rob_a   [NUM_REQ];
   logic [DATA_WIDTH-1:0]   value_a [NUM_REQ];
   logic [DATA_WIDTH-1:0]   dest_a  [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign rob_a[gi]   = req_rob_ix_in[gi*ROB_IX_WIDTH +: ROB_IX_WIDTH];
         assign value_a[gi] = req_value_in[gi*DATA_WIDTH +: DATA_WIDTH];
         assign dest_a[gi]  = req_dest_in[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // A requester granted last edge still shows valid this cycle; mask it so it is not broadcast twice.
   assign elig = req_valid_in & ~read_out;

   always_comb begin
      scan      = '0;
      grant_any = 1'b0;
      grant_ix  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (scan >= NREQ_W) scan = scan - NREQ_W;
         if (!grant_any && elig[scan[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_ix  = scan[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      if (grant_any) grant_oh[grant_ix] = 1'b1;
   end

   assign grant_nxt_ptr = (grant_ix == LAST_IX) ? '0 : grant_ix + PTR_W'(1);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cdb_valid_out  <= 1'b0;
         cdb_rob_ix_out <= '0;
         cdb_value_out  <= '0;
         cdb_dest_out   <= '0;
         read_out       <= '0;
         rr_ptr         <= '0;
      end else begin
         cdb_valid_out <= grant_any;
         read_out      <= grant_oh;
         if (grant_any) begin
            rr_ptr         <= grant_nxt_ptr;
            cdb_rob_ix_out <= rob_a[grant_ix];
            cdb_value_out  <= value_a[grant_ix];
            cdb_dest_out   <= dest_a[grant_ix];
         end
      end
   end

`ifdef CDB_ARB_STATS_EN
   logic multi_elig;
   logic seen_elig;

   always_comb begin
      seen_elig  = 1'b0;
      multi_elig = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (elig[i]) begin
            if (seen_elig) multi_elig = 1'b1;
            seen_elig = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)
         conflict_count_out <= '0;
      else if (multi_elig && conflict_count_out != {CNT_WIDTH{1'b1}})
         conflict_count_out <= conflict_count_out + CNT_WIDTH'(1);
   end
`else
   assign conflict_count_out = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: reference model of FUs plus round-robin rules, monitor compares every cycle.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int RW = 3;
   localparam int CW = 16;
`ifdef CDB_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*RW-1:0] req_rob;
   logic [N*DW-1:0] req_val;
   logic [N*DW-1:0] req_dest;
   logic [N-1:0]  rd;
   logic          cdb_valid;
   logic [RW-1:0] cdb_rob;
   logic [DW-1:0] cdb_val;
   logic [DW-1:0] cdb_dest;
   logic [CW-1:0] cnt;

   cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ROB_IX_WIDTH(RW), .CNT_WIDTH(CW)) dut (
      .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_rob_ix_in(req_rob),
      .req_value_in(req_val), .req_dest_in(req_dest), .read_out(rd), .cdb_valid_out(cdb_valid),
      .cdb_rob_ix_out(cdb_rob), .cdb_value_out(cdb_val), .cdb_dest_out(cdb_dest),
      .conflict_count_out(cnt));

   typedef struct {
      bit            rst;
      bit            vld;
      int            idx;
      logic [RW-1:0] rob;
      logic [DW-1:0] val;
      logic [DW-1:0] dest;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   int            log_g[$];
   logic [DW-1:0] log_v[$];
   logic [RW-1:0] log_r[$];
   logic [CW-1:0] log_c[$];
   int            n_tests = 0;
   int            n_fail  = 0;

   bit            pend [N];
   logic [RW-1:0] f_rob [N];
   logic [DW-1:0] f_val [N];
   logic [DW-1:0] f_dest[N];
   int            m_ptr   = 0;
   int            g_prev  = -1;
   int            g_prev2 = -1;
   longint        m_cnt   = 0;
   int            n_drv   = 0;
   bit            fix_en  = 1'b0;
   logic [RW-1:0] fix_rob;
   logic [DW-1:0] fix_val;
   logic [DW-1:0] fix_dest;

   task automatic chk(input string name, input longint got, input longint expv);
      n_tests++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
      end
   endtask

   // One cycle of stimulus: FU bookkeeping, input drive, and the expected result of the coming edge.
   task automatic drive(input bit r, input logic [N-1:0] new_req);
      exp_t e;
      int   g;
      int   n_elig;
      int   j;
      @(negedge clk);
      if (g_prev2 >= 0) pend[g_prev2] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (new_req[i] && !pend[i]) begin
            pend[i]   = 1'b1;
            f_rob[i]  = fix_en ? fix_rob  : RW'($urandom);
            f_val[i]  = fix_en ? fix_val  : DW'($urandom);
            f_dest[i] = fix_en ? fix_dest : DW'($urandom);
         end
      end
      rst = r;
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = pend[i];
         req_rob[i*RW +: RW]    = f_rob[i];
         req_val[i*DW +: DW]    = f_val[i];
         req_dest[i*DW +: DW]   = f_dest[i];
      end
      g = -1;
      e.rst = r; e.vld = 1'b0; e.idx = -1; e.rob = '0; e.val = '0; e.dest = '0;
      if (r) begin
         m_ptr = 0;
         m_cnt = 0;
      end else begin
         n_elig = 0;
         for (int i = 0; i < N; i++) if (pend[i] && i != g_prev) n_elig++;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && pend[j] && j != g_prev) g = j;
         end
         if (n_elig >= 2 && m_cnt < ((64'd1 << CW) - 1)) m_cnt++;
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            e.vld = 1'b1; e.idx = g;
            e.rob = f_rob[g]; e.val = f_val[g]; e.dest = f_dest[g];
         end
      end
      e.cnt = STATS ? CW'(m_cnt) : '0;
      sb.push_back(e);
      g_prev2 = g_prev;
      g_prev  = g;
      n_drv++;
   endtask

   initial begin : monitor
      exp_t e;
      int   dg;
      int   last_g;
      logic [N-1:0] exp_oh;
      last_g = -1;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            dg = -1;
            for (int i = 0; i < N; i++) if (rd[i]) dg = i;
            exp_oh = '0;
            if (e.idx >= 0) exp_oh[e.idx] = 1'b1;
            chk("read_out", rd, exp_oh);
            chk("cdb_valid", cdb_valid, e.vld);
            if (e.vld || e.rst) begin
               chk("cdb_rob_ix", cdb_rob, e.rob);
               chk("cdb_value", cdb_val, e.val);
               chk("cdb_dest", cdb_dest, e.dest);
            end
            chk("conflict_count", cnt, e.cnt);
            chk("no_repeat_grant", (dg >= 0 && dg == last_g), 0);
            last_g = dg;
            log_g.push_back(dg);
            log_v.push_back(cdb_val);
            log_r.push_back(cdb_rob);
            log_c.push_back(cnt);
         end
      end
   end

   initial begin : stim
      int sB, sC, sD, n0, n1;
      rst = 1'b1; req_valid = '0; req_rob = '0; req_val = '0; req_dest = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; f_rob[i] = '0; f_val[i] = '0; f_dest[i] = '0;
      end
      fix_rob = 3'd5; fix_val = 32'hDEAD_BEEF; fix_dest = 32'h0000_1234;

      // reset with all FUs requesting, then round-robin drain
      drive(1'b1, 4'b1111);
      drive(1'b1, 4'b0000);
      repeat (6) drive(1'b0, 4'b0000);

      // single FU
      sB = n_drv;
      fix_en = 1'b1;
      drive(1'b0, 4'b0010);
      fix_en = 1'b0;
      repeat (4) drive(1'b0, 4'b0000);

      // pointer wrap: grant 2, then 3 before 0
      sC = n_drv;
      drive(1'b0, 4'b0100);
      repeat (3) drive(1'b0, 4'b0000);
      drive(1'b0, 4'b1001);
      repeat (4) drive(1'b0, 4'b0000);

      // persistent requester 0 against a one-shot requester 2
      sD = n_drv;
      drive(1'b0, 4'b0101);
      repeat (5) drive(1'b0, 4'b0001);
      repeat (4) drive(1'b0, 4'b0000);

      // random traffic with a mid-run reset
      for (int c = 0; c < 400; c++) begin
         drive(c == 200, 4'($urandom_range(0, 15)) & (($urandom_range(0, 3) != 0) ? 4'hF : 4'h0));
      end
      repeat (6) drive(1'b0, 4'b0000);

      @(posedge clk);
      #2;
      chk("sb_drained", sb.size(), 0);
      chk("log_len", log_g.size(), n_drv);
      if (log_g.size() >= n_drv) begin
         chk("reset_no_grant0", log_g[0], -1);
         chk("reset_no_grant1", log_g[1], -1);
         chk("rr_grant0", log_g[2], 0);
         chk("rr_grant1", log_g[3], 1);
         chk("rr_grant2", log_g[4], 2);
         chk("rr_grant3", log_g[5], 3);
         chk("rr_idle_after", log_g[6], -1);
         chk("stats_count", log_c[7], STATS ? 3 : 0);
         chk("single_grant", log_g[sB], 1);
         chk("single_rob", log_r[sB], 5);
         chk("single_value", log_v[sB], 32'hDEAD_BEEF);
         n1 = 0;
         for (int i = sB + 1; i <= sB + 4; i++) if (log_g[i] == 1) n1++;
         chk("single_no_dup", n1, 0);
         chk("wrap_first", log_g[sC], 2);
         chk("wrap_3_first", log_g[sC+4], 3);
         chk("wrap_0_next", log_g[sC+5], 0);
         chk("persist_b_latency", (log_g[sD] == 2 || log_g[sD+1] == 2), 1);
         n0 = 0;
         for (int i = sD; i < sD + 10; i++) if (log_g[i] == 0) n0++;
         chk("persist_a_served", n0 >= 3, 1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) among functional units (ALU, multiplier, divider, memory/branch) whose results are complete.
- Each FU holds valid_out high until it receives a one-cycle read_in pulse; this block supplies that pulse and drives the registered CDB broadcast.
- The CDB broadcast feeds the ROB and all reservation stations.
- Replaces ad-hoc fixed-priority CDB muxing with round-robin, starvation-free scheduling.

Parameters:
- NUM_REQ, 4, number of requesting FUs; index 0=ALU, 1=MUL, 2=DIV, 3=MEM/branch.
- DATA_WIDTH, 32, result value width.
- ROB_IX_WIDTH, 3, ROB index width (ROB SIZE=8).
- CNT_WIDTH, 16, width of the optional statistics counter.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- req_valid_in  input  NUM_REQ  bit i high = FU i holds a completed result.
- req_rob_ix_in  input  NUM_REQ*ROB_IX_WIDTH  packed ROB indices, slice i = FU i.
- req_value_in  input  NUM_REQ*DATA_WIDTH  packed results, slice i = FU i.
- req_dest_in  input  NUM_REQ*DATA_WIDTH  packed destinations, slice i = FU i (forwarded unchanged).
- read_out  output  NUM_REQ  one-hot, one-cycle pulse; drives FU i read_in.
- cdb_valid_out  output  1  CDB broadcast valid.
- cdb_rob_ix_out  output  ROB_IX_WIDTH  broadcast ROB index.
- cdb_value_out  output  DATA_WIDTH  broadcast value.
- cdb_dest_out  output  DATA_WIDTH  broadcast destination.
- conflict_count_out  output  CNT_WIDTH  statistics counter; see Optional Feature.

Behaviour:
- Reset (rst_in high at a clock edge): cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_dest_out=0, read_out=0, rr_ptr=0, conflict_count_out=0. Reset overrides any in-flight grant; no broadcast occurs on that edge.
- Eligibility per cycle: elig[i] = req_valid_in[i] && !read_out[i]. This masks a requester granted on the previous edge, whose valid has not yet dropped, so no result is broadcast twice.
- Selection (combinational): scan elig starting at rr_ptr, ascending, wrapping at NUM_REQ-1 to 0. The first set bit is g.
- On the edge when any elig bit is set:
  - cdb_valid_out<=1; cdb_rob_ix_out/value/dest<=slice g.
  - read_out<=one-hot(g).
  - rr_ptr<=(g+1) mod NUM_REQ.
- On the edge when no elig bit is set: cdb_valid_out<=0, read_out<=0, rr_ptr holds. The data outputs hold their last values, which are don't-care while invalid.
- Latency: req_valid_in sampled high in cycle t -> broadcast and read pulse visible in cycle t+1 (1 cycle).
- Throughput: one broadcast per cycle when distinct requesters alternate. A single requester is granted at most every other cycle because of the mask.
- read_out is always one-hot or zero. It is asserted in exactly the same cycle as cdb_valid_out and refers to the same FU.
- Requests with a set valid are never dropped. A pending request waits at most NUM_REQ-1 grants to others.
- NUM_REQ must be at least 2. rr_ptr width is $clog2(NUM_REQ), and wrap is explicit for non-power-of-two NUM_REQ.
- No state machine beyond rr_ptr, output registers and the optional counter. The block is purely edge-registered with no combinational path from req_* to outputs.

Optional Feature:
- Macro CDB_ARB_STATS_EN.
- Defined: conflict_count_out increments by 1 on every edge where popcount(elig) is 2 or more (arbitration contention). It saturates at all-ones and clears on reset.
- Not defined: conflict_count_out is tied to 0 and no counter logic is synthesized. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_in 2 cycles with all req_valid_in=4'b1111 -> read_out=0, cdb_valid_out=0 throughout; first grant after release goes to index 0.
- Single FU: req_valid_in[1]=1, rob_ix=5, value=32'hDEAD_BEEF, held until read_out[1], then dropped next cycle -> exactly one broadcast (cdb_valid_out=1, rob_ix=5, value=DEADBEEF) one cycle after assertion; no duplicate.
- Round-robin: all four valid continuously, each dropping one cycle after its read pulse -> grant order 0,1,2,3 on consecutive cycles; cdb_valid_out high 4 consecutive cycles.
- Fairness/wrap: rr_ptr=3 (after granting index 2), req 0 and 3 valid -> index 3 granted first, then index 0.
- Persistent requester: req 0 held high for 6 cycles, req 2 valid once -> req 0 never granted on consecutive cycles; req 2 granted within 2 cycles.
- Stats (CDB_ARB_STATS_EN): 3 cycles with 2 or more elig requesters -> conflict_count_out=3; without the macro -> conflict_count_out=0.
